// File: rtl/operand_demux.sv
// operand_demux
// -------------
// One-entry buffered 1-to-2 demultiplexer. An upstream beat (in_data, in_sel)
// is captured on an input handshake and offered on channel 0 or channel 1 the
// next cycle. The entry is held until that channel's consumer accepts it. A new
// beat may be captured on the same edge the held beat leaves, so a fully ready
// stream moves one beat per cycle and may switch channels every beat.
//
// Handshake rule (all three interfaces): a transfer happens on a rising clk
// edge where valid and ready are both 1. A producer holds valid and data
// stable until that transfer. ready never depends on the same side's valid.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake
//   in_data, in_sel      upstream word and destination (0 = ch0, 1 = ch1)
//   out0_valid/_ready    channel 0 handshake, out0_data channel 0 word
//   out1_valid/_ready    channel 1 handshake, out1_data channel 1 word
//   sel_q                select of the most recently accepted beat
//   cnt0, cnt1           completed transfers per channel, wrapping at 256
module operand_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             in_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready,
    output logic             sel_q,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_q;
    logic             in_hs;
    logic             out0_hs;
    logic             out1_hs;

    // Next-state and handshake decode. in_ready follows only the ready of the
    // channel currently holding the entry, so the entry can be replaced on the
    // edge it drains without a bubble.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b1;
        out0_hs   = 1'b0;
        out1_hs   = 1'b0;

        case (state)
            IDLE:    in_ready = 1'b1;
            HOLD0: begin
                in_ready = out0_ready;
                out0_hs  = out0_ready;
            end
            HOLD1: begin
                in_ready = out1_ready;
                out1_hs  = out1_ready;
            end
            default: in_ready = 1'b1;
        endcase

        in_hs = in_valid & in_ready;

        if (in_hs) begin
            state_nxt = in_sel ? HOLD1 : HOLD0;
        end else if (out0_hs || out1_hs) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= '0;
            sel_q  <= 1'b0;
            cnt0   <= 8'd0;
            cnt1   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (in_hs) begin
                data_q <= in_data;
                sel_q  <= in_sel;
            end
            if (out0_hs) cnt0 <= cnt0 + 8'd1;
            if (out1_hs) cnt1 <= cnt1 + 8'd1;
        end
    end

    // Only the active channel shows the stored word; the idle one reads zero.
    always_comb begin
        out0_valid = (state == HOLD0);
        out1_valid = (state == HOLD1);
        out0_data  = out0_valid ? data_q : '0;
        out1_data  = out1_valid ? data_q : '0;
    end

endmodule

// File: tb/tb_operand_demux.sv
// Testbench for operand_demux: directed scenarios plus a randomized stream,
// checked by a occupancy-level reference model and a scoreboard queue.
module tb_operand_demux;

    localparam int W = 8;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_sel;
    logic         in_ready;
    logic         out0_valid;
    logic [W-1:0] out0_data;
    logic         out0_ready;
    logic         out1_valid;
    logic [W-1:0] out1_data;
    logic         out1_ready;
    logic         sel_q;
    logic [7:0]   cnt0;
    logic [7:0]   cnt1;

    operand_demux #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .sel_q      (sel_q),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a one-slot buffer described by occupancy, the
    // channel it is waiting on, and per-channel transfer tallies.
    // Evaluated on the falling edge: first compare, then advance to what
    // the next rising edge must produce.
    // ------------------------------------------------------------------
    logic [W:0] exp_q[$];      // {sel, data} of accepted beats, in order
    bit         m_occ  = 0;
    bit         m_sel  = 0;
    bit         m_selq = 0;
    logic [7:0] m_cnt0 = 0;
    logic [7:0] m_cnt1 = 0;

    always @(negedge clk) begin
        bit take, acc;
        chk("in_ready", in_ready, !m_occ || (m_sel ? out1_ready : out0_ready));
        chk("out0_valid", out0_valid, m_occ && !m_sel);
        chk("out1_valid", out1_valid, m_occ && m_sel);
        chk("no_double_valid", out0_valid & out1_valid, 0);
        if (!(m_occ && !m_sel)) chk("out0_data_idle", out0_data, 0);
        if (!(m_occ && m_sel))  chk("out1_data_idle", out1_data, 0);
        chk("cnt0", cnt0, m_cnt0);
        chk("cnt1", cnt1, m_cnt1);
        chk("sel_q", sel_q, m_selq);

        if (!rst_n) begin
            m_occ = 0; m_sel = 0; m_selq = 0; m_cnt0 = 0; m_cnt1 = 0;
            exp_q.delete();
        end else begin
            take = m_occ && (m_sel ? out1_ready : out0_ready);
            acc  = in_valid && (!m_occ || take);
            if (take) begin
                if (m_sel) m_cnt1 = m_cnt1 + 1;
                else       m_cnt0 = m_cnt0 + 1;
            end
            if (acc) begin
                m_occ  = 1;
                m_sel  = in_sel;
                m_selq = in_sel;
                exp_q.push_back({in_sel, in_data});
            end else if (take) begin
                m_occ = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard monitor: whenever the DUT completes an output transfer,
    // the oldest expected beat must match channel and word.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst_n && ((out0_valid && out0_ready) || (out1_valid && out1_ready))) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (out0_valid) chk("out0_beat", {1'b0, out0_data}, e);
                else            chk("out1_beat", {1'b1, out1_data}, e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: apply inputs for exactly one rising edge, return #1 after it.
    // ------------------------------------------------------------------
    task automatic cycle(input bit v, input bit s, input logic [W-1:0] d,
                         input bit r0, input bit r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, 1, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        cycle(0, 0, '0, 0, 0);
        cycle(0, 0, '0, 0, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_cnt0", cnt0, 0);

        // Single route, accepted on the first edge after release.
        rst_n = 1'b1;
        cycle(1, 0, 8'hA5, 1, 0);
        chk("route_out0_valid", out0_valid, 1);
        chk("route_out0_data", out0_data, 8'hA5);
        chk("route_out1_data", out1_data, 8'h00);
        cycle(0, 0, '0, 1, 0);
        chk("route_cnt0", cnt0, 1);
        chk("route_idle", out0_valid | out1_valid, 0);

        // Backpressure on channel 1 while a second beat waits.
        cycle(1, 1, 8'h3C, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 8'h77, 1, 0);
        chk("bp_out1_data", out1_data, 8'h3C);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_sel_q", sel_q, 1);
        cycle(1, 0, 8'h77, 1, 1);
        chk("bp_cnt1", cnt1, 1);
        chk("bp_out0_data", out0_data, 8'h77);
        cycle(0, 0, '0, 1, 1);

        // Back-to-back beats alternating channels.
        cycle(1, 0, 8'h11, 1, 1);
        cycle(1, 1, 8'h22, 1, 1);
        chk("b2b_out1_valid", out1_valid, 1);
        cycle(1, 0, 8'h33, 1, 1);
        chk("b2b_out0_data", out0_data, 8'h33);
        cycle(0, 0, '0, 1, 1);
        chk("b2b_sel_q", sel_q, 0);
        chk("b2b_cnt0", cnt0, 4);

        // Counter wrap on channel 1, starting from a clean reset.
        rst_n = 1'b0;
        cycle(0, 0, '0, 1, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 255; i++) cycle(1, 1, W'($urandom), 1, 1);
        idle(2);
        chk("wrap_cnt1_255", cnt1, 255);
        cycle(1, 1, 8'hEE, 1, 1);
        idle(2);
        chk("wrap_cnt1_0", cnt1, 0);
        chk("wrap_cnt0", cnt0, 0);

        // Reset while a channel 0 beat is held.
        cycle(1, 0, 8'h5A, 0, 0);
        cycle(0, 0, '0, 0, 0);
        chk("hold_out0_data", out0_data, 8'h5A);
        rst_n = 1'b0;
        cycle(0, 0, '0, 0, 0);
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out0_data", out0_data, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        idle(3);
        chk("rst_no_spurious", cnt0, 0);

        // Random stream, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            cycle($urandom_range(0, 1), $urandom_range(0, 1), W'($urandom),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        end
        rst_n = 1'b1;
        idle(4);
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
